// File: rtl/bp_fe_ras_pkg.sv
// Shared types for the front-end return address stack controller:
// checkpoint record, controller state encoding and derived widths.
package bp_fe_ras_pkg;

  localparam int bp_fe_ras_els_gp   = 8;
  localparam int bp_fe_ras_idx_w_gp = $clog2(bp_fe_ras_els_gp);
  localparam int bp_fe_ras_cnt_w_gp = $clog2(bp_fe_ras_els_gp + 1);

  typedef struct packed {
    logic [bp_fe_ras_idx_w_gp-1:0] tos;
    logic [bp_fe_ras_cnt_w_gp-1:0] count;
  } bp_fe_ras_ckpt_s;

  typedef enum logic [1:0] {
    e_ready   = 2'd0,
    e_full    = 2'd1,
    e_recover = 2'd2
  } e_ras_ctrl_state;

endpackage

// File: rtl/bp_fe_ras_ckpt_fifo.sv
// Checkpoint FIFO for speculative RAS pointer state; clear drops everything,
// peek exposes the oldest entry without dequeuing it.
module bp_fe_ras_ckpt_fifo #(
  parameter int width_p = 7,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_i,
  input  logic                       deq_i,
  input  logic                       clear_i,
  input  logic [width_p-1:0]         data_i,
  output logic [width_p-1:0]         peek_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (enq_i) r_wptr <= r_wptr + ptr_w_lp'(1);
      if (deq_i) r_rptr <= r_rptr + ptr_w_lp'(1);
      case ({enq_i, deq_i})
        2'b10:   r_cnt <= r_cnt + cnt_w_lp'(1);
        2'b01:   r_cnt <= r_cnt - cnt_w_lp'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clk_i) begin
    if (enq_i && !clear_i) r_mem[r_wptr] <= data_i;
  end

  assign peek_o  = r_mem[r_rptr];
  assign full_o  = (r_cnt == cnt_w_lp'(els_p));
  assign empty_o = (r_cnt == '0);
  assign count_o = r_cnt;

endmodule

// File: rtl/bp_fe_ras_ctrl.sv
// Return address stack controller: owns TOS/occupancy, turns predicted
// call/return into array indices, checkpoints and restores on redirect.
module bp_fe_ras_ctrl
  import bp_fe_ras_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = bp_fe_ras_els_gp,
  parameter int ckpt_els_p    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         call_v_i,
  input  logic                         ret_v_i,
  input  logic [vaddr_width_p-1:0]     call_addr_i,
  output logic                         op_ready_o,
  output logic [vaddr_width_p-1:0]     ret_addr_o,
  output logic                         ret_addr_v_o,
  input  logic                         commit_i,
  input  logic                         flush_i,
  output logic                         ras_w_v_o,
  output logic [$clog2(ras_els_p)-1:0] ras_w_idx_o,
  output logic [vaddr_width_p-1:0]     ras_w_data_o,
  output logic [$clog2(ras_els_p)-1:0] ras_r_idx_o,
  input  logic [vaddr_width_p-1:0]     ras_r_data_i
);

  localparam int idx_w_lp  = $clog2(ras_els_p);
  localparam int cnt_w_lp  = $clog2(ras_els_p + 1);
  localparam int ccnt_w_lp = $clog2(ckpt_els_p + 1);
  localparam logic [cnt_w_lp-1:0]  cnt_max_lp   = cnt_w_lp'(ras_els_p);
  localparam logic [ccnt_w_lp-1:0] ckpt_last_lp = ccnt_w_lp'(ckpt_els_p - 1);

  e_ras_ctrl_state       r_state;
  logic [idx_w_lp-1:0]   r_tos;
  logic [cnt_w_lp-1:0]   r_count;

  bp_fe_ras_ckpt_s       w_ckpt_in;
  bp_fe_ras_ckpt_s       w_ckpt_peek;
  logic                  w_call_acc;
  logic                  w_ret_acc;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ccnt_w_lp-1:0]  w_fifo_cnt;

  assign op_ready_o   = (r_state == e_ready);
  assign w_call_acc   = call_v_i & op_ready_o & ~flush_i;
  assign w_ret_acc    = ret_v_i & ~call_v_i & op_ready_o & ~flush_i;
  assign w_enq        = (w_call_acc | w_ret_acc) & ~w_fifo_full;
  assign w_deq        = commit_i & ~flush_i & ~w_fifo_empty;
  assign w_ckpt_in    = '{tos: r_tos, count: r_count};

  assign ras_w_v_o    = w_call_acc;
  assign ras_w_idx_o  = r_tos + idx_w_lp'(1);
  assign ras_w_data_o = call_addr_i;
  assign ras_r_idx_o  = r_tos;
  assign ret_addr_o   = ras_r_data_i;
  assign ret_addr_v_o = (r_count != '0);

  bp_fe_ras_ckpt_fifo #(
    .width_p ($bits(bp_fe_ras_ckpt_s)),
    .els_p   (ckpt_els_p)
  ) u_ckpt_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (w_enq),
    .deq_i     (w_deq),
    .clear_i   (flush_i),
    .data_i    (w_ckpt_in),
    .peek_o    (w_ckpt_peek),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .count_o   (w_fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_ready;
      r_tos   <= idx_w_lp'(ras_els_p - 1);
      r_count <= '0;
    end else if (flush_i) begin
      // Oldest checkpoint is the state before the first squashed op.
      if (!w_fifo_empty) begin
        r_tos   <= w_ckpt_peek.tos;
        r_count <= w_ckpt_peek.count;
      end
      r_state <= e_recover;
    end else begin
      case (r_state)
        e_ready:   if (w_enq && !w_deq && (w_fifo_cnt == ckpt_last_lp)) r_state <= e_full;
        e_full:    if (w_deq) r_state <= e_ready;
        e_recover: r_state <= e_ready;
        default:   r_state <= e_ready;
      endcase
      if (w_call_acc) begin
        r_tos <= r_tos + idx_w_lp'(1);
        if (r_count != cnt_max_lp) r_count <= r_count + cnt_w_lp'(1);
      end else if (w_ret_acc && (r_count != '0)) begin
        r_tos   <= r_tos - idx_w_lp'(1);
        r_count <= r_count - cnt_w_lp'(1);
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// Directed plus randomized bench for bp_fe_ras_ctrl against a stack/queue model.
module tb_bp_fe_ras_ctrl;

  localparam int VW  = 39;
  localparam int ELS = 8;
  localparam int CK  = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          call_v_i, ret_v_i, commit_i, flush_i;
  logic [VW-1:0] call_addr_i;
  logic          op_ready_o, ret_addr_v_o, ras_w_v_o;
  logic [VW-1:0] ret_addr_o, ras_w_data_o, ras_r_data_i;
  logic [2:0]    ras_w_idx_o, ras_r_idx_o;

  always #5 clk_i = ~clk_i;

  bp_fe_ras_ctrl #(.vaddr_width_p(VW), .ras_els_p(ELS), .ckpt_els_p(CK)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .call_v_i     (call_v_i),
    .ret_v_i      (ret_v_i),
    .call_addr_i  (call_addr_i),
    .op_ready_o   (op_ready_o),
    .ret_addr_o   (ret_addr_o),
    .ret_addr_v_o (ret_addr_v_o),
    .commit_i     (commit_i),
    .flush_i      (flush_i),
    .ras_w_v_o    (ras_w_v_o),
    .ras_w_idx_o  (ras_w_idx_o),
    .ras_w_data_o (ras_w_data_o),
    .ras_r_idx_o  (ras_r_idx_o),
    .ras_r_data_i (ras_r_data_i)
  );

  // The storage array the controller drives.
  logic [VW-1:0] arr [ELS];
  always @(posedge clk_i) if (ras_w_v_o) arr[ras_w_idx_o] <= ras_w_data_o;
  assign ras_r_data_i = arr[ras_r_idx_o];

  // Reference model: a circular stack with a queue of pointer snapshots.
  int            m_tos, m_cnt;
  int            q_tos[$];
  int            q_cnt[$];
  bit            m_rec;
  logic [VW-1:0] m_mem [ELS];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tos = ELS - 1;
    m_cnt = 0;
    q_tos.delete();
    q_cnt.delete();
    m_rec = 1'b0;
  endtask

  task automatic check_outputs(input bit c, input bit f, input logic [VW-1:0] a, input bit rdy);
    chk("op_ready", 64'(op_ready_o), 64'(rdy));
    chk("w_v", 64'(ras_w_v_o), 64'(rdy && c && !f));
    if (rdy && c && !f) begin
      chk("w_idx", 64'(ras_w_idx_o), 64'((m_tos + 1) % ELS));
      chk("w_data", 64'(ras_w_data_o), 64'(a));
    end
    chk("r_idx", 64'(ras_r_idx_o), 64'(m_tos));
    chk("ret_v", 64'(ret_addr_v_o), 64'(m_cnt != 0));
    if (m_cnt != 0) chk("ret_addr", 64'(ret_addr_o), 64'(m_mem[m_tos]));
  endtask

  // Drive one cycle of inputs at posedge+1, check before the next edge, advance model.
  task automatic step(input bit c, input bit r, input logic [VW-1:0] a, input bit cm, input bit f);
    bit rdy;
    call_v_i = c; ret_v_i = r; call_addr_i = a; commit_i = cm; flush_i = f;
    #2;
    rdy = !m_rec && (q_tos.size() < CK);
    check_outputs(c, f, a, rdy);
    @(posedge clk_i);
    if (f) begin
      if (q_tos.size() > 0) begin
        m_tos = q_tos[0];
        m_cnt = q_cnt[0];
      end
      q_tos.delete();
      q_cnt.delete();
      m_rec = 1'b1;
    end else begin
      m_rec = 1'b0;
      if (cm && q_tos.size() > 0) begin
        void'(q_tos.pop_front());
        void'(q_cnt.pop_front());
      end
      if (rdy && (c || r)) begin
        q_tos.push_back(m_tos);
        q_cnt.push_back(m_cnt);
      end
      if (rdy && c) begin
        m_tos = (m_tos + 1) % ELS;
        m_mem[m_tos] = a;
        if (m_cnt < ELS) m_cnt++;
      end else if (rdy && r && m_cnt > 0) begin
        m_tos = (m_tos + ELS - 1) % ELS;
        m_cnt--;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < CK; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must react immediately.
  task automatic pulse_reset();
    call_v_i = 0; ret_v_i = 0; commit_i = 0; flush_i = 0; call_addr_i = '0;
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < ELS; i++) begin
      arr[i]   = '0;
      m_mem[i] = '0;
    end
    reset_n_i = 1'b0;
    call_v_i = 0; ret_v_i = 0; commit_i = 0; flush_i = 0; call_addr_i = '0;
    model_reset();
    #12;
    check_outputs(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Three calls then three returns, LIFO order.
    step(1, 0, 39'h100, 1, 0);
    step(1, 0, 39'h200, 1, 0);
    step(1, 0, 39'h300, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, '0, 1, 0);
    idle();
    drain();

    // Nine calls into an eight-entry stack: wrap overwrites the oldest.
    for (int i = 0; i < 9; i++) step(1, 0, 39'(32'h1000 + i), 1, 0);
    step(0, 1, '0, 1, 0);
    drain();

    // Four uncommitted ops fill the checkpoint FIFO.
    for (int i = 0; i < 4; i++) step(1, 0, 39'(32'h2000 + i), 0, 0);
    idle();
    step(0, 0, '0, 1, 0);
    idle();
    drain();

    // Restore to tos=2,count=3 after a speculative call/call/ret.
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 39'(32'h3000 + i), 1, 0);
    drain();
    step(1, 0, 39'h3100, 0, 0);
    step(1, 0, 39'h3200, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    idle();
    idle();

    // Flush wins over call and commit in the same cycle; flush during recover.
    step(1, 0, 39'h4000, 0, 0);
    step(1, 0, 39'h4100, 1, 1);
    step(0, 0, '0, 0, 1);
    idle();
    idle();

    // Return on an empty stack, then reset mid-stream.
    pulse_reset();
    step(0, 1, '0, 0, 0);
    idle();
    step(1, 0, 39'h5000, 0, 0);
    pulse_reset();
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sel;
      bit c, r, cm, f;
      sel = int'($urandom_range(0, 99));
      c   = (sel < 40);
      r   = (sel >= 40) && (sel < 70);
      cm  = ($urandom_range(0, 2) == 0);
      f   = ($urandom_range(0, 19) == 0);
      step(c, r, 39'({$urandom, $urandom}), cm, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
